// File: rtl/fp_divider.sv
// fp_divider -- binary32 divider, restoring long division, truncating result.
// Special operands resolve in one step; finite operands take 25 division
// cycles plus one normalisation cycle. Subnormal operands are read as zero.

// add_33bits -- plain ripple-carry adder used for the trial subtraction.
module add_33bits (
   input  logic [32:0] a,
   input  logic [32:0] b,
   input  logic        cin,
   output logic [32:0] sum,
   output logic        cout
);

   // Ripple the carry bit by bit from the LSB.
   always_comb begin
      logic carry;
      carry = cin;
      sum   = '0;
      for (int i = 0; i < 33; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end

endmodule

module fp_divider (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [31:0] i_data_one,
   input  logic [31:0] i_data_two,
   output logic [31:0] o_data,
   output logic        o_done,
   output logic        o_busy,
   output logic        o_invalid,
   output logic        o_div_zero,
   output logic        o_overflow,
   output logic        o_underflow
);

   // state  | meaning
   // IDLE   | waiting for i_start, operands decoded combinationally
   // CALC   | 25 restoring-division steps, one quotient bit per cycle
   // NORM   | normalise quotient, apply exponent bias, range check
   // DONE   | publish result and flags, pulse o_done, back to IDLE
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_NORM = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]        state;
   logic [4:0]        cnt;
   logic [24:0]       rem;
   logic [24:0]       quo;
   logic [23:0]       mb_r;
   logic              sign_r;
   logic signed [9:0] exp_diff;
   logic [31:0]       res_data;
   logic [3:0]        res_flags;   // {invalid, div_zero, overflow, underflow}

   // operand decode
   logic       sa, sb, sign_n;
   logic [7:0] ea, eb;
   logic [22:0] fa, fb;
   logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic       special;
   logic [31:0] sp_data;
   logic [3:0]  sp_flags;

   assign sa = i_data_one[31];
   assign sb = i_data_two[31];
   assign ea = i_data_one[30:23];
   assign eb = i_data_two[30:23];
   assign fa = i_data_one[22:0];
   assign fb = i_data_two[22:0];
   assign sign_n = sa ^ sb;
   assign a_zero = (ea == 8'd0);
   assign b_zero = (eb == 8'd0);
   assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
   assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
   assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
   assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);

   // Special-case result selection in priority order.
   always_comb begin
      special  = 1'b1;
      sp_data  = 32'd0;
      sp_flags = 4'b0000;
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         sp_data  = 32'h7FC0_0000;
         sp_flags = 4'b1000;
      end else if (b_zero && !a_zero && !a_inf) begin
         sp_data  = {sign_n, 8'hFF, 23'd0};
         sp_flags = 4'b0100;
      end else if (a_inf) begin
         sp_data  = {sign_n, 8'hFF, 23'd0};
      end else if (b_inf || a_zero) begin
         sp_data  = {sign_n, 31'd0};
      end else begin
         special  = 1'b0;
      end
   end

   // trial subtraction R - mb; carry-out set means R >= mb
   logic [32:0] sub_sum;
   logic        sub_ge;
   logic        unused_sum_hi;

   add_33bits u_sub (
      .a    ({8'd0, rem}),
      .b    (~{9'd0, mb_r}),
      .cin  (1'b1),
      .sum  (sub_sum),
      .cout (sub_ge)
   );

   assign unused_sum_hi = ^sub_sum[32:24];

   // Normalisation: quotient lies in [2^23, 2^25), pick the leading bit.
   logic signed [9:0] exp_n;
   logic [22:0]       frac_n;
   logic [31:0]       norm_data;
   logic [3:0]        norm_flags;

   always_comb begin
      exp_n      = exp_diff + (quo[24] ? 10'sd127 : 10'sd126);
      frac_n     = quo[24] ? quo[23:1] : quo[22:0];
      norm_data  = {sign_r, exp_n[7:0], frac_n};
      norm_flags = 4'b0000;
      if (exp_n >= 10'sd255) begin
         norm_data  = {sign_r, 8'hFF, 23'd0};
         norm_flags = 4'b0010;
      end else if (exp_n <= 10'sd0) begin
         norm_data  = {sign_r, 31'd0};
         norm_flags = 4'b0001;
      end
   end

   assign o_busy = (state == S_CALC) || (state == S_NORM);

   // Controller, datapath and output registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         rem         <= '0;
         quo         <= '0;
         mb_r        <= '0;
         sign_r      <= 1'b0;
         exp_diff    <= '0;
         res_data    <= '0;
         res_flags   <= '0;
         o_data      <= '0;
         o_done      <= 1'b0;
         o_invalid   <= 1'b0;
         o_div_zero  <= 1'b0;
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  o_invalid   <= 1'b0;
                  o_div_zero  <= 1'b0;
                  o_overflow  <= 1'b0;
                  o_underflow <= 1'b0;
                  sign_r      <= sign_n;
                  exp_diff    <= $signed({2'b00, ea}) - $signed({2'b00, eb});
                  mb_r        <= {1'b1, fb};
                  rem         <= {2'b01, fa};
                  quo         <= '0;
                  cnt         <= 5'd24;
                  if (special) begin
                     res_data  <= sp_data;
                     res_flags <= sp_flags;
                     state     <= S_DONE;
                  end else begin
                     state     <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               quo <= {quo[23:0], sub_ge};
               rem <= sub_ge ? {sub_sum[23:0], 1'b0} : {rem[23:0], 1'b0};
               if (cnt == 5'd0) state <= S_NORM;
               else             cnt   <= cnt - 5'd1;
            end
            S_NORM: begin
               res_data  <= norm_data;
               res_flags <= norm_flags;
               state     <= S_DONE;
            end
            default: begin
               o_data      <= res_data;
               o_invalid   <= res_flags[3];
               o_div_zero  <= res_flags[2];
               o_overflow  <= res_flags[1];
               o_underflow <= res_flags[0];
               o_done      <= 1'b1;
               state       <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/fp_divider.md
FP_DIVIDER -- requirements
Module: fp_divider

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at IEEE-754 binary32.
REQ-002 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 i_rst  input  1  reset, asynchronous and active-high.
REQ-004 i_start  input  1  request pulse; operands SHALL be sampled on the same edge.
REQ-005 i_data_one  input  32  dividend, binary32.
REQ-006 i_data_two  input  32  divisor, binary32.
REQ-007 o_data  output  32  quotient, binary32.
REQ-008 o_done  output  1  one-cycle pulse; o_data and the flags are valid while it is high.
REQ-009 o_busy  output  1  high while an accepted request is in progress.
REQ-010 o_invalid, o_div_zero, o_overflow, o_underflow  output  1 each  exception flags.

Function
REQ-011 The FSM SHALL have exactly four states: IDLE, CALC, NORM and DONE.
REQ-012 The FSM SHALL accept i_start only in IDLE; i_start SHALL be ignored in CALC, NORM and DONE.
REQ-013 On accept, the block SHALL compute sign = sign(a) XOR sign(b) and unpack mantissas with the hidden 1 (24 bits).
REQ-014 On accept, the block SHALL compute the biased exponent difference ea-eb in at least 10-bit signed arithmetic.
REQ-015 Any operand with exponent 0 SHALL be treated as zero (subnormals flushed, no subnormal outputs).
REQ-016 Special-case priority, resolved at accept, next state DONE directly: NaN operand, 0/0 or inf/inf -> 0x7FC00000 with o_invalid.
REQ-017 Next: finite nonzero / 0 -> signed inf with o_div_zero.
REQ-018 Next: inf / finite -> signed inf (no flag).
REQ-019 Next: finite / inf, or 0 / nonzero -> signed zero (no flag).
REQ-020 Otherwise the FSM SHALL go to CALC with remainder R = ma and quotient Q = 0.
REQ-021 CALC SHALL last exactly 25 cycles; each cycle: if R >= mb then shift 1 into Q and R = (R-mb)<<1, else shift 0 into Q and R = R<<1.
REQ-022 The trial subtraction SHALL use the add_33bits ripple adder (zero-extended operands, subtrahend inverted, carry-in 1); carry-out 1 means R >= mb.
REQ-023 After CALC, Q[24:0] SHALL equal floor(ma*2^24/mb).
REQ-024 NORM: if Q[24]=1, fraction = Q[23:1] and exp = ea-eb+127; else fraction = Q[22:0] and exp = ea-eb+126.
REQ-025 Rounding SHALL be round-toward-zero (truncation); no guard or sticky bits are kept.
REQ-026 NORM: if exp >= 255, the result SHALL be signed inf with o_overflow.
REQ-027 NORM: if exp <= 0, the result SHALL be signed zero with o_underflow.
REQ-028 o_data and all flags SHALL be registered on entry to DONE and held until the next accept.
REQ-029 On the next accept, all four flags SHALL clear.
REQ-030 DONE SHALL last one cycle with o_done=1, then return to IDLE.
REQ-031 o_busy SHALL be 1 exactly in CALC and NORM.
REQ-032 Normal latency: if i_start is sampled at edge k, o_done SHALL be high in the cycle after edge k+27.
REQ-033 Special-case latency: o_done SHALL be high in the cycle after edge k+1.
REQ-034 At most one flag SHALL be set per result.

Reset
REQ-035 Asserting i_rst SHALL immediately force IDLE and drive o_data=0, o_done=0, o_busy=0 and all flags to 0, in any state.
REQ-036 A request aborted by reset SHALL produce no o_done.
REQ-037 The first i_start after i_rst deasserts SHALL be accepted normally.

Verification
REQ-038 Test 6.0/2.0: 0x40C00000 / 0x40000000 -> o_data 0x40400000, no flags, o_done exactly 27 edges after the start edge.
REQ-039 Test 1.0/3.0: 0x3F800000 / 0x40400000 -> 0x3EAAAAAA (truncated), no flags.
REQ-040 Test 1.0/0.0: 0x3F800000 / 0x00000000 -> 0x7F800000 with o_div_zero; -1.0/0 (0xBF800000) -> 0xFF800000; o_done 1 edge after start.
REQ-041 Test 0/0: 0x00000000 / 0x00000000 -> 0x7FC00000 with o_invalid; 0x7FC00001 / 0x3F800000 -> 0x7FC00000 with o_invalid.
REQ-042 Overflow/underflow: 0x7F000000 / 0x3F000000 -> 0x7F800000 with o_overflow; 0x00800000 / 0x40000000 -> 0x00000000 with o_underflow.
REQ-043 Control: a second i_start during CALC SHALL be ignored, so the first result and one o_done only are produced.
REQ-044 Control: i_rst pulsed 10 cycles into CALC -> outputs 0 immediately, no o_done; a following 6.0/2.0 -> 0x40400000.
